// File: rtl/multdiv_unit_if.sv
// Operand, start and result signals between the execute stage and the multiply/divide unit.
interface multdiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit working on operand magnitudes,
// one result bit per cycle, with the sign applied on the last iteration.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    multdiv_unit_if.slave bus_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned AccW     = 2 * WIDTH;
    localparam logic [5:0]  LastIter = 6'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             sign_q, sign_d;
    logic             is_mul_q, is_mul_d;
    logic             div_exc_q, div_exc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] op_a, op_b, mag_a, mag_b;
    logic             start, b_zero, div_ovf;

    assign op_a    = bus_io.data_operandA;
    assign op_b    = bus_io.data_operandB;
    assign mag_a   = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b   = op_b[WIDTH-1] ? -op_b : op_b;
    assign start   = bus_io.ctrl_MULT | bus_io.ctrl_DIV;
    assign b_zero  = (op_b == '0);
    assign div_ovf = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);

    // Multiply: acc = {partial product, remaining multiplier}; opb holds the multiplicand.
    logic [WIDTH:0]  mul_hi;
    logic [AccW-1:0] mul_next;
    assign mul_hi   = acc_q[0] ? ({1'b0, acc_q[AccW-1:WIDTH]} + {1'b0, opb_q})
                               : {1'b0, acc_q[AccW-1:WIDTH]};
    assign mul_next = {mul_hi, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}; opb holds the divisor.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic [AccW-1:0]  div_next;
    assign rem_sh   = acc_q[AccW-1:WIDTH-1];
    assign rem_diff = rem_sh[WIDTH-1:0] - opb_q;
    assign div_next = (rem_sh >= {1'b0, opb_q})
                    ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                    : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    logic [AccW-1:0] step;
    logic            hi_same;
    assign step    = is_mul_q ? mul_next : div_next;
    assign hi_same = (&acc_q[AccW-1:WIDTH-1]) | ~(|acc_q[AccW-1:WIDTH-1]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        sign_d    = sign_q;
        is_mul_d  = is_mul_q;
        div_exc_d = div_exc_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        if (start) begin
            // A new start always wins, aborting whatever is in flight.
            sign_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            cnt_d     = '0;
            is_mul_d  = bus_io.ctrl_MULT;
            div_exc_d = 1'b0;
            if (bus_io.ctrl_MULT) begin
                acc_d   = {{WIDTH{1'b0}}, mag_b};
                opb_d   = mag_a;
                state_d = StMul;
            end else begin
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                opb_d   = mag_b;
                state_d = StDiv;
                if (b_zero) begin
                    acc_d     = '0;
                    div_exc_d = 1'b1;
                    state_d   = StDone;
                end else if (div_ovf) begin
                    div_exc_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                StMul, StDiv: begin
                    acc_d = step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LastIter) begin
                        state_d = StDone;
                        if (sign_q) begin
                            acc_d = is_mul_q ? -step
                                             : {step[AccW-1:WIDTH], -step[WIDTH-1:0]};
                        end
                    end
                end
                StDone: begin
                    result_d = acc_q[WIDTH-1:0];
                    exc_d    = is_mul_q ? ~hi_same : div_exc_q;
                    rdy_d    = 1'b1;
                    state_d  = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            sign_q    <= 1'b0;
            is_mul_q  <= 1'b0;
            div_exc_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            sign_q    <= sign_d;
            is_mul_q  <= is_mul_d;
            div_exc_q <= div_exc_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
        end
    end

    // The RDY cycle still counts as busy so the stall covers the result write.
    assign bus_io.busy           = (state_q != StIdle) | rdy_q;
    assign bus_io.data_result    = result_q;
    assign bus_io.data_exception = exc_q;
    assign bus_io.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed corner cases plus random multiply/divide traffic.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv_unit_if #(.WIDTH(32)) bus ();
    multdiv_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus_io(bus));

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic logic [32:0] model(input logic is_mul, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        longint q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {p != longint'($signed(p[31:0])), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = longint'($signed(a)) / longint'($signed(b));
        return {1'b0, q[31:0]};
    endfunction

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (bus.data_resultRDY === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy result=%h at cycle %0d", bus.data_result, cyc);
            end else begin
                e_mon = exp_q.pop_front();
                check("result", bus.data_result, e_mon.res);
                check("exception", {31'd0, bus.data_exception}, {31'd0, e_mon.exc});
                check("rdy_cycle", cyc, e_mon.due);
                check("busy_at_rdy", {31'd0, bus.busy}, 32'd1);
            end
        end
    end

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input bit abort_prev);
        logic [32:0] r;
        exp_t        e;
        @(posedge clock);
        #1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        if (abort_prev && exp_q.size() > 0) void'(exp_q.pop_back());
        r     = model(m, a, b);
        e.res = r[31:0];
        e.exc = r[32];
        e.due = cyc + ((!m && b == 32'd0) ? 2 : 34);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout outstanding=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] a, b;
        logic [31:0] corners [4];
        int          sel;
        corners[0] = 32'd0;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'd1;

        reset = 1'b1;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exc", {31'd0, bus.data_exception}, 32'd0);
        check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        issue(1'b1, 1'b0, 32'd7, -32'sd6, 1'b0);                 wait_done();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   wait_done();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'd1, 1'b0);           wait_done();
        issue(1'b0, 1'b1, -32'sd7, 32'd2, 1'b0);                 wait_done();
        issue(1'b0, 1'b1, 32'd100, 32'd0, 1'b0);                 wait_done();
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   wait_done();

        // Restart: the multiply is sampled at E10 of the divide.
        issue(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0);
        repeat (8) @(posedge clock);
        issue(1'b1, 1'b0, 32'd5, 32'd5, 1'b1);
        wait_done();
        repeat (3) @(negedge clock);
        check("result_hold", bus.data_result, 32'd25);

        // Reset sampled at E15 of a multiply.
        issue(1'b1, 1'b0, 32'h1234, 32'h5678, 1'b0);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clock);
        #1;
        check("midreset_result", bus.data_result, 32'd0);
        check("midreset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        issue(1'b1, 1'b0, 32'd3, 32'd3, 1'b0);                   wait_done();

        issue(1'b1, 1'b1, 32'd12, 32'd4, 1'b0);                  wait_done();

        // Back-to-back: second start sampled in the RDY cycle of the first.
        issue(1'b0, 1'b1, 32'd1000, 32'd7, 1'b0);
        repeat (32) @(posedge clock);
        issue(1'b1, 1'b0, -32'sd9, 32'd11, 1'b0);
        wait_done();

        for (int n = 0; n < 20; n++) begin
            sel = int'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 1) == 1) a = 32'($signed(a) >>> 16);
            if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 3)];
            else if ($urandom_range(0, 1) == 1) b = 32'($signed(b) >>> 20);
            issue(sel == 0 || sel == 2, sel != 0, a, b, 1'b0);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
